// File: rtl/suprloco_loader_pkg.sv
// Shared types and constants for the SuprLoco ROM download sequencer.
package suprloco_loader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic [4:0] SEL_MAIN = 5'b00001;
    localparam logic [4:0] SEL_SND  = 5'b00010;
    localparam logic [4:0] SEL_TILE = 5'b00100;
    localparam logic [4:0] SEL_SPR  = 5'b01000;
    localparam logic [4:0] SEL_PROM = 5'b10000;

    localparam logic [15:0] IDX_ROM = 16'd0;
    localparam logic [15:0] IDX_DIP = 16'd254;

endpackage

// File: rtl/suprloco_rom_region_dec.sv
// Combinational byte-address to ROM-region decoder: one-hot select plus
// region-relative address; valid is low past the last region.
module suprloco_rom_region_dec
    import suprloco_loader_pkg::*;
#(
    parameter logic [23:0] MainEnd = 24'h0C000,
    parameter logic [23:0] SndEnd  = 24'h0E000,
    parameter logic [23:0] TileEnd = 24'h14000,
    parameter logic [23:0] SprEnd  = 24'h1C000,
    parameter logic [23:0] PromEnd = 24'h1C200
) (
    input  logic [26:0] addr_i,
    output logic [4:0]  sel_o,
    output logic [16:0] rel_addr_o,
    output logic        valid_o
);

    // Only the low 17 bits of the difference are kept, so subtracting the
    // low bits of the base gives the same result without a wide subtractor.
    always_comb begin
        sel_o      = '0;
        rel_addr_o = '0;
        valid_o    = 1'b0;
        if (addr_i < 27'(MainEnd)) begin
            sel_o      = SEL_MAIN;
            rel_addr_o = addr_i[16:0];
            valid_o    = 1'b1;
        end else if (addr_i < 27'(SndEnd)) begin
            sel_o      = SEL_SND;
            rel_addr_o = addr_i[16:0] - MainEnd[16:0];
            valid_o    = 1'b1;
        end else if (addr_i < 27'(TileEnd)) begin
            sel_o      = SEL_TILE;
            rel_addr_o = addr_i[16:0] - SndEnd[16:0];
            valid_o    = 1'b1;
        end else if (addr_i < 27'(SprEnd)) begin
            sel_o      = SEL_SPR;
            rel_addr_o = addr_i[16:0] - TileEnd[16:0];
            valid_o    = 1'b1;
        end else if (addr_i < 27'(PromEnd)) begin
            sel_o      = SEL_PROM;
            rel_addr_o = addr_i[16:0] - SprEnd[16:0];
            valid_o    = 1'b1;
        end
    end

endmodule

// File: rtl/suprloco_rom_loader.sv
// hps_io ioctl download sequencer: routes ROM bytes to a req/ack write port,
// captures DIP bytes and holds the core in reset. Optional SUPRLOCO_LOADER_CHECKSUM_EN.
module suprloco_rom_loader
    import suprloco_loader_pkg::*;
#(
    parameter logic [23:0] MAIN_END = 24'h0C000,
    parameter logic [23:0] SND_END  = 24'h0E000,
    parameter logic [23:0] TILE_END = 24'h14000,
    parameter logic [23:0] SPR_END  = 24'h1C000,
    parameter logic [23:0] PROM_END = 24'h1C200,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_INITRST_n,
    input  logic        i_IOCTL_DOWNLOAD,
    input  logic [15:0] i_IOCTL_INDEX,
    input  logic [26:0] i_IOCTL_ADDR,
    input  logic [7:0]  i_IOCTL_DATA,
    input  logic        i_IOCTL_WR,
    output logic        o_IOCTL_WAIT,
    output logic [16:0] o_ROM_ADDR,
    output logic [7:0]  o_ROM_DATA,
    output logic [4:0]  o_ROM_SEL,
    output logic        o_WR_REQ,
    input  logic        i_WR_ACK,
    output logic [15:0] o_DIP,
    output logic        o_CORE_RST,
    output logic        o_OVERRUN
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] o_CHECKSUM,
    output logic        o_CHECKSUM_VLD
`endif
);

    localparam logic [15:0] HoldLoad = 16'(RST_HOLD);

    state_e      state_q, state_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  sel_q, sel_d;
    logic [15:0] dip_q, dip_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        core_rst_q, core_rst_d;
    logic        overrun_q, overrun_d;
    logic        dl_seen_q, dl_seen_d;

    logic [4:0]  dec_sel;
    logic [16:0] dec_addr;
    logic        dec_valid;

    suprloco_rom_region_dec #(
        .MainEnd (MAIN_END),
        .SndEnd  (SND_END),
        .TileEnd (TILE_END),
        .SprEnd  (SPR_END),
        .PromEnd (PROM_END)
    ) u_dec (
        .addr_i     (i_IOCTL_ADDR),
        .sel_o      (dec_sel),
        .rel_addr_o (dec_addr),
        .valid_o    (dec_valid)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        dip_d      = dip_q;
        hold_cnt_d = hold_cnt_q;
        core_rst_d = core_rst_q;
        overrun_d  = overrun_q;
        // Remembers that a download happened so its end can start the hold.
        dl_seen_d  = dl_seen_q | i_IOCTL_DOWNLOAD;
        if (i_IOCTL_DOWNLOAD) begin
            core_rst_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_IOCTL_WR && i_IOCTL_DOWNLOAD) begin
                    if (i_IOCTL_INDEX == IDX_ROM && dec_valid) begin
                        addr_d  = dec_addr;
                        data_d  = i_IOCTL_DATA;
                        sel_d   = dec_sel;
                        state_d = StReq;
                    end else if (i_IOCTL_INDEX == IDX_DIP) begin
                        if (i_IOCTL_ADDR == 27'd0) begin
                            dip_d[7:0] = i_IOCTL_DATA;
                        end else if (i_IOCTL_ADDR == 27'd1) begin
                            dip_d[15:8] = i_IOCTL_DATA;
                        end
                    end
                end else if (!i_IOCTL_DOWNLOAD && dl_seen_q) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                    dl_seen_d  = 1'b0;
                end
            end
            StReq: begin
                if (i_IOCTL_WR) begin
                    overrun_d = 1'b1;
                end
                if (i_WR_ACK) begin
                    sel_d = '0;
                    if (!i_IOCTL_DOWNLOAD && dl_seen_q) begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLoad;
                        dl_seen_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (i_IOCTL_WR) begin
                    overrun_d = 1'b1;
                end
                if (i_IOCTL_DOWNLOAD) begin
                    state_d = StIdle;
                end else if (hold_cnt_q <= 16'd1) begin
                    hold_cnt_d = '0;
                    core_rst_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            dip_q      <= 16'hFFFF;
            hold_cnt_q <= '0;
            core_rst_q <= 1'b1;
            overrun_q  <= 1'b0;
            dl_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            dip_q      <= dip_d;
            hold_cnt_q <= hold_cnt_d;
            core_rst_q <= core_rst_d;
            overrun_q  <= overrun_d;
            dl_seen_q  <= dl_seen_d;
        end
    end

    assign o_WR_REQ     = (state_q == StReq);
    assign o_IOCTL_WAIT = (state_q == StReq);
    assign o_ROM_ADDR   = addr_q;
    assign o_ROM_DATA   = data_q;
    assign o_ROM_SEL    = sel_q;
    assign o_DIP        = dip_q;
    assign o_CORE_RST   = core_rst_q | i_IOCTL_DOWNLOAD;
    assign o_OVERRUN    = overrun_q;

`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
    logic        dl_q;
    logic [15:0] csum_q, csum_d;
    logic        csum_vld_q, csum_vld_d;

    always_comb begin
        csum_d     = csum_q;
        csum_vld_d = csum_vld_q;
        if (state_q == StReq && i_WR_ACK) begin
            csum_d = csum_q + {8'h00, data_q};
        end
        if (state_d == StHold && state_q != StHold) begin
            csum_vld_d = 1'b1;
        end
        if (i_IOCTL_DOWNLOAD && !dl_q) begin
            csum_d     = '0;
            csum_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            dl_q       <= 1'b0;
            csum_q     <= '0;
            csum_vld_q <= 1'b0;
        end else begin
            dl_q       <= i_IOCTL_DOWNLOAD;
            csum_q     <= csum_d;
            csum_vld_q <= csum_vld_d;
        end
    end

    assign o_CHECKSUM     = csum_q;
    assign o_CHECKSUM_VLD = csum_vld_q;
`endif

endmodule

// File: tb/tb_suprloco_rom_loader.sv
// Scoreboard bench for suprloco_rom_loader: directed boundary cases plus
// randomized downloads checked against a region-table reference model.
module tb_suprloco_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        download = 1'b0;
    logic [15:0] index = '0;
    logic [26:0] addr = '0;
    logic [7:0]  data = '0;
    logic        wr = 1'b0;
    logic        ack = 1'b0;
    logic        o_IOCTL_WAIT;
    logic [16:0] o_ROM_ADDR;
    logic [7:0]  o_ROM_DATA;
    logic [4:0]  o_ROM_SEL;
    logic        o_WR_REQ;
    logic [15:0] o_DIP;
    logic        o_CORE_RST;
    logic        o_OVERRUN;
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
    logic [15:0] csum;
    logic        csum_vld;
`endif

    suprloco_rom_loader dut (
        .i_EMU_MCLK       (clk),
        .i_EMU_INITRST_n  (rst_n),
        .i_IOCTL_DOWNLOAD (download),
        .i_IOCTL_INDEX    (index),
        .i_IOCTL_ADDR     (addr),
        .i_IOCTL_DATA     (data),
        .i_IOCTL_WR       (wr),
        .o_IOCTL_WAIT     (o_IOCTL_WAIT),
        .o_ROM_ADDR       (o_ROM_ADDR),
        .o_ROM_DATA       (o_ROM_DATA),
        .o_ROM_SEL        (o_ROM_SEL),
        .o_WR_REQ         (o_WR_REQ),
        .i_WR_ACK         (ack),
        .o_DIP            (o_DIP),
        .o_CORE_RST       (o_CORE_RST),
        .o_OVERRUN        (o_OVERRUN)
`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
        ,
        .o_CHECKSUM       (csum),
        .o_CHECKSUM_VLD   (csum_vld)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        logic [16:0] addr;
        logic [7:0]  data;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    bit          wait_seen = 1'b0;
    logic [15:0] dip_m = 16'hFFFF;
    logic [15:0] csum_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected want none", name);
    endtask

    // Region table: inclusive base, exclusive end; select bit i marks region i.
    function automatic bit ref_dec(input logic [26:0] a, output logic [4:0] s,
                                   output logic [16:0] rel);
        int unsigned b[6] = '{32'h0, 32'h0C000, 32'h0E000, 32'h14000, 32'h1C000, 32'h1C200};
        s   = '0;
        rel = '0;
        for (int i = 0; i < 5; i++) begin
            if (32'(a) >= b[i] && 32'(a) < b[i+1]) begin
                s   = 5'(1 << i);
                rel = 17'(32'(a) - b[i]);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic strobe(input logic [15:0] idx, input logic [26:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        index = idx;
        addr  = a;
        data  = d;
        wr    = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!o_WR_REQ) return;
        end
        fail("wait_idle");
    endtask

    task automatic issue(input logic [15:0] idx, input logic [26:0] a, input logic [7:0] d,
                         input int dly);
        exp_t        e;
        logic [4:0]  s;
        logic [16:0] rel;
        ack_delay = dly;
        if (idx == 16'd0 && ref_dec(a, s, rel)) begin
            e.sel  = s;
            e.addr = rel;
            e.data = d;
            e.len  = dly + 1;
            sb.push_back(e);
            csum_m = csum_m + {8'h00, d};
        end else if (idx == 16'd254) begin
            if (a == 27'd0) dip_m[7:0] = d;
            else if (a == 27'd1) dip_m[15:8] = d;
        end
        strobe(idx, a, d);
        wait_idle();
    endtask

    // Write target: acknowledges ack_delay clocks after the request rises.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            ack = 1'b0;
            if (o_WR_REQ && ack_en) begin
                if (cnt >= ack_delay) begin
                    ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each request and checks its length.
    initial begin
        exp_t cur;
        bit   in_req, have;
        int   req_len, wait_len;
        in_req = 0; have = 0; req_len = 0; wait_len = 0;
        forever begin
            @(negedge clk);
            if (o_IOCTL_WAIT) wait_seen = 1'b1;
            if (!rst_n) begin
                in_req = 0; have = 0; req_len = 0; wait_len = 0;
            end else begin
                if (o_IOCTL_WAIT) wait_len++;
                if (o_WR_REQ) begin
                    if (!in_req) begin
                        in_req  = 1;
                        req_len = 0;
                        if (sb.size() == 0) begin
                            have = 0;
                            fail("unexpected_req");
                        end else begin
                            have = 1;
                            cur  = sb.pop_front();
                            check("rom_sel", 32'(o_ROM_SEL), 32'(cur.sel));
                            check("rom_addr", 32'(o_ROM_ADDR), 32'(cur.addr));
                            check("rom_data", 32'(o_ROM_DATA), 32'(cur.data));
                        end
                    end
                    req_len++;
                end else if (in_req) begin
                    in_req = 0;
                    if (have) begin
                        check("req_len", 32'(req_len), 32'(cur.len));
                        check("wait_len", 32'(wait_len), 32'(cur.len));
                        check("sel_clear", 32'(o_ROM_SEL), 32'd0);
                    end
                    wait_len = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [4:0]  s;
        logic [16:0] rel;
        int          cnt;
        int unsigned bnd[5] = '{32'h0C000, 32'h0E000, 32'h14000, 32'h1C000, 32'h1C200};

        #25;
        check("rst_wait", 32'(o_IOCTL_WAIT), 32'd0);
        check("rst_req", 32'(o_WR_REQ), 32'd0);
        check("rst_sel", 32'(o_ROM_SEL), 32'd0);
        check("rst_addr", 32'(o_ROM_ADDR), 32'd0);
        check("rst_data", 32'(o_ROM_DATA), 32'd0);
        check("rst_dip", 32'(o_DIP), 32'hFFFF);
        check("rst_core", 32'(o_CORE_RST), 32'd1);
        check("rst_overrun", 32'(o_OVERRUN), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("core_rst_before_dl", 32'(o_CORE_RST), 32'd1);

        download = 1'b1;
        issue(16'd0, 27'h0BFFF, 8'hA5, 3);
        issue(16'd0, 27'h0C000, 8'h5C, 1);
        issue(16'd0, 27'h1C1FF, 8'hC3, 0);
        issue(16'd0, 27'h1C200, 8'h99, 2);
        check("drop_wait", 32'(o_IOCTL_WAIT), 32'd0);
        @(negedge clk);
        check("drop_req", 32'(o_WR_REQ), 32'd0);

        wait_seen = 1'b0;
        issue(16'd254, 27'd0, 8'h3C, 0);
        issue(16'd254, 27'd1, 8'h81, 0);
        issue(16'd254, 27'd2, 8'h55, 0);
        check("dip", 32'(o_DIP), 32'h813C);
        check("dip_no_wait", 32'(wait_seen), 32'd0);

        check("overrun_clear", 32'(o_OVERRUN), 32'd0);
        ack_delay = 4;
        void'(ref_dec(27'h00123, s, rel));
        e.sel = s; e.addr = rel; e.data = 8'h5A; e.len = 5;
        sb.push_back(e);
        strobe(16'd0, 27'h00123, 8'h5A);
        strobe(16'd0, 27'h00456, 8'h77);
        wait_idle();
        check("overrun_set", 32'(o_OVERRUN), 32'd1);

        ack_delay = 5;
        void'(ref_dec(27'h0E010, s, rel));
        e.sel = s; e.addr = rel; e.data = 8'h3E; e.len = 6;
        sb.push_back(e);
        strobe(16'd0, 27'h0E010, 8'h3E);
        download = 1'b0;
        wait_idle();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!o_CORE_RST) break;
            cnt++;
            @(negedge clk);
        end
        check("hold_len", 32'(cnt), 32'd16);

        @(posedge clk); #1;
        download = 1'b1;
        csum_m   = '0;
        #1;
        check("core_rst_on_dl", 32'(o_CORE_RST), 32'd1);
        for (int n = 0; n < 40; n++) begin
            int          r;
            logic [15:0] idx;
            logic [26:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                idx = 16'd0;
                if ($urandom_range(0, 1) == 1)
                    a = 27'(bnd[$urandom_range(0, 4)] - 1 + $urandom_range(0, 1));
                else
                    a = 27'($urandom_range(0, 32'h1C400));
            end else begin
                idx = (r < 9) ? 16'd254 : 16'd7;
                a   = 27'($urandom_range(0, 3));
            end
            issue(idx, a, 8'($urandom), int'($urandom_range(0, 4)));
        end
        check("dip_random", 32'(o_DIP), 32'(dip_m));

`ifdef SUPRLOCO_LOADER_CHECKSUM_EN
        download = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        download = 1'b1;
        csum_m   = '0;
        @(negedge clk);
        @(negedge clk);
        check("csum_clear", 32'(csum), 32'd0);
        check("csum_vld_clear", 32'(csum_vld), 32'd0);
        issue(16'd0, 27'h00010, 8'h01, 1);
        issue(16'd0, 27'h00020, 8'hFF, 1);
        issue(16'd0, 27'h00030, 8'h10, 1);
        @(posedge clk); #1;
        download = 1'b0;
        repeat (20) @(negedge clk);
        check("csum", 32'(csum), 32'(csum_m));
        check("csum_vld", 32'(csum_vld), 32'd1);
        @(posedge clk); #1;
        download = 1'b1;
`endif

        ack_en = 1'b0;
        void'(ref_dec(27'h00005, s, rel));
        e.sel = s; e.addr = rel; e.data = 8'h11; e.len = 1;
        sb.push_back(e);
        strobe(16'd0, 27'h00005, 8'h11);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(o_WR_REQ), 32'd0);
        check("arst_wait", 32'(o_IOCTL_WAIT), 32'd0);
        check("arst_core", 32'(o_CORE_RST), 32'd1);
        check("arst_dip", 32'(o_DIP), 32'hFFFF);
        check("arst_sel", 32'(o_ROM_SEL), 32'd0);
        check("arst_overrun", 32'(o_OVERRUN), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
